lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 11 +
 rtl/lsu_if.sv | 8 +
 rtl/lsu_align.sv | 22 ++
 rtl/lsu.sv | 82 ++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encodings, funct3 codes, default timeout and command legality check
package lsu_pkg;
  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  function automatic logic bad_cmd(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    logic ill;
    ill = st ? f3 > F3_W : (f3 == 3'b011 || f3[2:1] == 2'b11);
    return ill || (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: single-outstanding memory bus between the lsu and its memory
interface lsu_if;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: store lane replication/strobes and load byte/half extraction with extension
module lsu_align import lsu_pkg::*; (
  input  logic [1:0]  st_lo,
  input  logic [1:0]  st_sz,
  input  logic [31:0] sdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [1:0]  ld_lo,
  input  logic [2:0]  ld_f3,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);
  logic [15:0] h;
  logic [7:0] b;
  always_comb begin
    wdata = st_sz[1] ? sdata : st_sz[0] ? {2{sdata[15:0]}} : {4{sdata[7:0]}};
    wstrb = st_sz[1] ? 4'b1111 : (st_sz[0] ? 4'b0011 : 4'b0001) << st_lo;
    h = ld_lo[1] ? rdata[31:16] : rdata[15:0];
    b = ld_lo[0] ? h[15:8] : h[7:0];
    ldata = ld_f3[1] ? rdata : ld_f3[0] ? {{16{h[15] & ~ld_f3[2]}}, h} : {{24{b[7] & ~ld_f3[2]}}, b};
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit with alignment checks and bus timeout
module lsu import lsu_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] sdata,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wb_wen,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_rd,
  lsu_if.master       bus
);
  logic [1:0] state, lo_r;
  logic [2:0] f3_r;
  logic st_r, bad;
  logic [31:0] cnt, ea, st_wdata, ld_data;
  logic [3:0] st_wstrb;
  assign ea = base + offset;
  assign bad = bad_cmd(is_store, funct3, ea[1:0]);
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign bus.mem_req = state == S_REQ;
  assign bus.mem_we = bus.mem_req & st_r;
  lsu_align u_align (
    .st_lo(ea[1:0]), .st_sz(funct3[1:0]), .sdata(sdata), .wdata(st_wdata), .wstrb(st_wstrb),
    .ld_lo(lo_r), .ld_f3(f3_r), .rdata(bus.mem_rdata), .ldata(ld_data)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      err <= 1'b0;
      wb_wen <= 1'b0;
      wb_wdata <= '0;
      wb_rd <= '0;
      cnt <= '0;
      st_r <= 1'b0;
      f3_r <= '0;
      lo_r <= '0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      err <= 1'b0;
      wb_wen <= 1'b0;
      if (state == S_IDLE && start) begin
        st_r <= is_store;
        f3_r <= funct3;
        lo_r <= ea[1:0];
        wb_rd <= rd_in;
        wb_wdata <= '0;
        cnt <= '0;
        bus.mem_addr <= {ea[31:2], 2'b00};
        bus.mem_wdata <= is_store ? st_wdata : '0;
        bus.mem_wstrb <= is_store ? st_wstrb : 4'b0000;
        state <= bad ? S_DONE : S_REQ;
        err <= bad;
      end else if (state == S_REQ) begin
        cnt <= cnt + 32'd1;
        // an ack in the expiry cycle wins over the timeout
        if (bus.mem_ack) begin
          state <= S_DONE;
          wb_wdata <= st_r ? '0 : ld_data;
          wb_wen <= !st_r && wb_rd != 5'd0;
        end else if (TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_CYCLES - 1) begin
          state <= S_DONE;
          err <= 1'b1;
        end
      end else if (state == S_DONE) begin
        state <= S_IDLE;
      end
    end
  end
endmodule
